// File: rtl/core_issue_pkg.sv
// Shared types for the dual-issue controller: the decoded instruction record,
// the per-instruction issue classification and the helper that derives it.
package core_issue_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_W   = 5;

  typedef struct packed {
    logic is_branch;        // conditional branch or jump
    logic is_load;
    logic is_store;
    logic is_mul;
    logic is_div;
    logic is_csr;
    logic is_tlb;
    logic is_cacop;
    logic is_barrier;
    logic is_idle;
    logic is_ertn;
    logic is_syscall_break;
  } decode_info_t;

  typedef struct packed {
    logic [1:0][REG_W-1:0] r_reg;
    logic [REG_W-1:0]      w_reg;
  } reg_info_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } predict_t;

  typedef struct packed {
    logic       fetch_excp;
    logic [5:0] ecode;
  } excp_t;

  typedef struct packed {
    decode_info_t decode_info;
    reg_info_t    reg_info;
    logic [31:0]  pc;
    predict_t     predict;
    excp_t        excp;
  } inst_t;

  typedef struct packed {
    logic serial;
    logic branch;
    logic mem;
    logic long_lat;
  } issue_class_t;

  // Serial instructions must run alone on a drained scoreboard.
  function automatic issue_class_t get_issue_class(input decode_info_t d, input logic fetch_excp);
    issue_class_t c;
    c.serial   = d.is_csr | d.is_tlb | d.is_cacop | d.is_barrier | d.is_idle |
                 d.is_ertn | d.is_syscall_break | fetch_excp;
    c.branch   = d.is_branch;
    c.mem      = d.is_load | d.is_store;
    c.long_lat = d.is_load | d.is_mul | d.is_div;
    return c;
  endfunction

endpackage

// File: rtl/core_issue_scoreboard.sv
// Pending-writer scoreboard for long-latency results: one bit per GPR,
// cleared by writeback ports, set by issue, with six hit query ports.
module core_issue_scoreboard
  import core_issue_pkg::*;
#(
  parameter int REG_NUM  = core_issue_pkg::REG_NUM,
  parameter int WB_PORTS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [WB_PORTS-1:0]             clr_valid,
  input  logic [WB_PORTS-1:0][REG_W-1:0]  clr_reg,
  input  logic [1:0]                      set_valid,
  input  logic [1:0][REG_W-1:0]           set_reg,
  input  logic [5:0][REG_W-1:0]           query_reg,
  output logic [5:0]                      hit,
  output logic                            empty
);

  logic [REG_NUM-1:0] sb_reg;
  logic [REG_NUM-1:0] sb_next;

  // Sets are applied after clears so a younger writer wins over a retiring one.
  always_comb begin
    sb_next = sb_reg;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (clr_valid[p] && (clr_reg[p] != '0)) begin
        sb_next[clr_reg[p]] = 1'b0;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (set_valid[s] && (set_reg[s] != '0)) begin
        sb_next[set_reg[s]] = 1'b1;
      end
    end
    sb_next[0] = 1'b0;
    if (flush) begin
      sb_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hit
      assign hit[gi] = (query_reg[gi] != '0) && sb_reg[query_reg[gi]];
    end
  endgenerate

  assign empty = ~|sb_reg;

endmodule

// File: rtl/core_issue_ctrl.sv
// Dual-issue controller: picks 0/1/2 instructions from the FIFO head, checks
// scoreboard and intra-pair hazards, and registers the issued pair for EX.
module core_issue_ctrl
  import core_issue_pkg::*;
#(
  parameter int REG_NUM  = core_issue_pkg::REG_NUM,
  parameter int WB_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [1:0]                     inst_valid_i,
  input  inst_t [1:0]                    inst_i,
  output logic [1:0]                     issue_o,
  input  logic                           ex_ready_i,
  output logic [1:0]                     ex_valid_o,
  output inst_t [1:0]                    ex_inst_o,
  input  logic [WB_PORTS-1:0]            wb_valid_i,
  input  logic [WB_PORTS-1:0][REG_W-1:0] wb_reg_i
);

  issue_class_t [1:0]            cls;
  logic [5:0][REG_W-1:0]         query_reg;
  logic [5:0]                    hit;
  logic [1:0]                    sb_hit;
  logic                          sb_empty;
  logic [1:0]                    set_valid;
  logic [1:0][REG_W-1:0]         set_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign cls[gi]             = get_issue_class(inst_i[gi].decode_info, inst_i[gi].excp.fetch_excp);
      assign query_reg[3*gi]     = inst_i[gi].reg_info.r_reg[0];
      assign query_reg[3*gi + 1] = inst_i[gi].reg_info.r_reg[1];
      assign query_reg[3*gi + 2] = inst_i[gi].reg_info.w_reg;
      assign sb_hit[gi]          = |hit[3*gi +: 3];
      assign set_valid[gi]       = issue_o[gi] && cls[gi].long_lat;
      assign set_reg[gi]         = inst_i[gi].reg_info.w_reg;
    end
  endgenerate

  core_issue_scoreboard #(
    .REG_NUM  (REG_NUM),
    .WB_PORTS (WB_PORTS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .clr_valid (wb_valid_i),
    .clr_reg   (wb_reg_i),
    .set_valid (set_valid),
    .set_reg   (set_reg),
    .query_reg (query_reg),
    .hit       (hit),
    .empty     (sb_empty)
  );

  logic [REG_W-1:0] w0;
  logic             pair_raw;
  logic             pair_waw;
  logic             pair_struct;
  logic             slot0_ok;
  logic             slot1_ok;

  assign w0          = inst_i[0].reg_info.w_reg;
  assign pair_raw    = (w0 != '0) && ((w0 == inst_i[1].reg_info.r_reg[0]) ||
                                      (w0 == inst_i[1].reg_info.r_reg[1]));
  assign pair_waw    = (w0 != '0) && (w0 == inst_i[1].reg_info.w_reg);
  assign pair_struct = cls[0].branch ||
                       (cls[0].mem && cls[1].mem) ||
                       (cls[0].long_lat && cls[1].long_lat);

  // rst_n gates issue so the FIFO never pops while the pipeline is in reset.
  assign slot0_ok = rst_n && inst_valid_i[0] && ex_ready_i && !flush_i && !sb_hit[0] &&
                    (!cls[0].serial || sb_empty);

  assign slot1_ok = slot0_ok && inst_valid_i[1] && !sb_hit[1] &&
                    !cls[0].serial && !cls[1].serial &&
                    !pair_struct && !pair_raw && !pair_waw;

  assign issue_o = {slot1_ok, slot0_ok};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_o <= 2'b00;
      ex_inst_o  <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 2'b00;
    end else if (ex_ready_i) begin
      ex_valid_o <= issue_o;
      ex_inst_o  <= inst_i;
    end
  end

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: a table of single-cycle pairing vectors,
// hand sequences for multi-cycle stalls/flush/reset, and a short random invariant run.
module tb_core_issue_ctrl;
  import core_issue_pkg::*;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_MUL = 3, K_DIV = 4, K_BR = 5, K_CSR = 6, K_EXC = 7;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush_i;
  logic [1:0]         inst_valid_i;
  inst_t [1:0]        inst_i;
  logic [1:0]         issue_o;
  logic               ex_ready_i;
  logic [1:0]         ex_valid_o;
  inst_t [1:0]        ex_inst_o;
  logic [1:0]         wb_valid_i;
  logic [1:0][4:0]    wb_reg_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  core_issue_ctrl #(.REG_NUM(32), .WB_PORTS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .inst_valid_i (inst_valid_i),
    .inst_i       (inst_i),
    .issue_o      (issue_o),
    .ex_ready_i   (ex_ready_i),
    .ex_valid_o   (ex_valid_o),
    .ex_inst_o    (ex_inst_o),
    .wb_valid_i   (wb_valid_i),
    .wb_reg_i     (wb_reg_i)
  );

  always #5 clk = ~clk;

  function automatic inst_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] pc);
    inst_t i;
    i = '0;
    i.pc = pc;
    i.reg_info.r_reg[0] = rs1;
    i.reg_info.r_reg[1] = rs2;
    i.reg_info.w_reg = rd;
    case (kind)
      K_LD:  i.decode_info.is_load = 1'b1;
      K_ST:  begin i.decode_info.is_store = 1'b1; i.reg_info.w_reg = 5'd0; end
      K_MUL: i.decode_info.is_mul = 1'b1;
      K_DIV: i.decode_info.is_div = 1'b1;
      K_BR:  begin i.decode_info.is_branch = 1'b1; i.reg_info.w_reg = 5'd0; end
      K_CSR: i.decode_info.is_csr = 1'b1;
      K_EXC: begin i.excp.fetch_excp = 1'b1; i.reg_info = '0; end
      default: ;
    endcase
    return i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    inst_valid_i = 2'b00;
    inst_i       = '0;
    flush_i      = 1'b0;
    ex_ready_i   = 1'b1;
    wb_valid_i   = 2'b00;
    wb_reg_i     = '0;
  endtask

  task automatic drive(input logic [1:0] v, input inst_t i0, input inst_t i1);
    inst_valid_i = v;
    inst_i[0]    = i0;
    inst_i[1]    = i1;
  endtask

  typedef struct packed {
    logic [1:0] valid;
    inst_t      i0;
    inst_t      i1;
    logic       ready;
    logic [1:0] exp_issue;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  logic [31:0] tb_sb;

  initial begin
    vecs[0]  = '{2'b11, mk(K_ALU, 4, 1, 2, 32'h10),  mk(K_ALU, 5, 1, 3, 32'h14),  1'b1, 2'b11};
    vecs[1]  = '{2'b11, mk(K_LD, 6, 1, 0, 32'h20),   mk(K_ALU, 7, 6, 1, 32'h24),  1'b1, 2'b01};
    vecs[2]  = '{2'b11, mk(K_BR, 0, 1, 2, 32'h30),   mk(K_ALU, 5, 1, 3, 32'h34),  1'b1, 2'b01};
    vecs[3]  = '{2'b11, mk(K_LD, 6, 1, 0, 32'h40),   mk(K_ST, 0, 2, 3, 32'h44),   1'b1, 2'b01};
    vecs[4]  = '{2'b11, mk(K_ALU, 8, 1, 2, 32'h50),  mk(K_ALU, 8, 3, 4, 32'h54),  1'b1, 2'b01};
    vecs[5]  = '{2'b11, mk(K_MUL, 10, 1, 2, 32'h60), mk(K_DIV, 11, 3, 4, 32'h64), 1'b1, 2'b01};
    vecs[6]  = '{2'b11, mk(K_CSR, 9, 1, 0, 32'h70),  mk(K_ALU, 5, 1, 3, 32'h74),  1'b1, 2'b01};
    vecs[7]  = '{2'b11, mk(K_ALU, 5, 1, 2, 32'h80),  mk(K_CSR, 3, 4, 0, 32'h84),  1'b1, 2'b01};
    vecs[8]  = '{2'b01, mk(K_ALU, 5, 1, 2, 32'h90),  mk(K_ALU, 6, 1, 2, 32'h94),  1'b1, 2'b01};
    vecs[9]  = '{2'b00, mk(K_ALU, 5, 1, 2, 32'hA0),  mk(K_ALU, 6, 1, 2, 32'hA4),  1'b1, 2'b00};
    vecs[10] = '{2'b11, mk(K_ALU, 4, 1, 2, 32'hB0),  mk(K_ALU, 5, 1, 3, 32'hB4),  1'b0, 2'b00};
    vecs[11] = '{2'b11, mk(K_EXC, 0, 0, 0, 32'hC0),  mk(K_ALU, 5, 1, 3, 32'hC4),  1'b1, 2'b01};
    vecs[12] = '{2'b11, mk(K_ALU, 0, 1, 2, 32'hD0),  mk(K_ALU, 5, 0, 0, 32'hD4),  1'b1, 2'b11};
    vecs[13] = '{2'b11, mk(K_LD, 0, 1, 0, 32'hE0),   mk(K_ALU, 5, 1, 2, 32'hE4),  1'b1, 2'b11};
    vecs[14] = '{2'b11, mk(K_MUL, 10, 1, 2, 32'hF0), mk(K_ALU, 11, 1, 2, 32'hF4), 1'b1, 2'b11};

    // Reset state
    idle();
    rst_n = 1'b0;
    drive(2'b11, mk(K_ALU, 4, 1, 2, 32'h0), mk(K_ALU, 5, 1, 3, 32'h4));
    at_neg(); check("reset_issue", 32'(issue_o), 32'h0);
    tick();
    at_neg(); check("reset_ex_valid", 32'(ex_valid_o), 32'h0);
    tick();
    rst_n = 1'b1;
    idle();
    tick();

    // Table vectors, each from an empty scoreboard; a flush cleans up afterwards
    for (int k = 0; k < NVEC; k++) begin
      idle();
      drive(vecs[k].valid, vecs[k].i0, vecs[k].i1);
      ex_ready_i = vecs[k].ready;
      at_neg(); check($sformatf("vec%0d_issue", k), 32'(issue_o), 32'(vecs[k].exp_issue));
      tick();
      idle();
      flush_i = 1'b1;
      at_neg();
      check($sformatf("vec%0d_ex_valid", k), 32'(ex_valid_o),
            vecs[k].ready ? 32'(vecs[k].exp_issue) : 32'h0);
      if (vecs[k].ready && vecs[k].exp_issue[0])
        check($sformatf("vec%0d_ex_pc", k), ex_inst_o[0].pc, vecs[k].i0.pc);
      tick();
      flush_i = 1'b0;
    end

    // Load then dependent add: stall until writeback of r6
    idle();
    drive(2'b11, mk(K_LD, 6, 1, 0, 32'h100), mk(K_ALU, 7, 6, 1, 32'h104));
    at_neg(); check("ld_pair_issue", 32'(issue_o), 32'h1);
    tick();
    drive(2'b01, mk(K_ALU, 7, 6, 1, 32'h104), '0);
    at_neg(); check("raw_stall_a", 32'(issue_o), 32'h0);
    tick();
    at_neg(); check("raw_stall_b", 32'(issue_o), 32'h0);
    tick();
    wb_valid_i = 2'b01; wb_reg_i[0] = 5'd6;
    at_neg(); check("raw_stall_wb_cycle", 32'(issue_o), 32'h0);
    tick();
    wb_valid_i = 2'b00;
    at_neg(); check("raw_issue_after_wb", 32'(issue_o), 32'h1);
    tick();
    idle();
    at_neg(); check("raw_ex_valid", 32'(ex_valid_o), 32'h1);
    check("raw_ex_pc", ex_inst_o[0].pc, 32'h104);
    tick();

    // Serial csr waits for an empty scoreboard, then issues alone
    drive(2'b01, mk(K_LD, 9, 1, 0, 32'h110), '0);
    at_neg(); check("ld_r9_issue", 32'(issue_o), 32'h1);
    tick();
    drive(2'b11, mk(K_CSR, 3, 4, 0, 32'h114), mk(K_ALU, 5, 1, 2, 32'h118));
    at_neg(); check("csr_wait_sb", 32'(issue_o), 32'h0);
    tick();
    wb_valid_i = 2'b10; wb_reg_i[1] = 5'd9;
    at_neg(); check("csr_wait_wb_cycle", 32'(issue_o), 32'h0);
    tick();
    wb_valid_i = 2'b00;
    at_neg(); check("csr_alone", 32'(issue_o), 32'h1);
    tick();
    idle();

    // Set wins over same-cycle clear; flush drops EX and scoreboard
    wb_valid_i = 2'b01; wb_reg_i[0] = 5'd12;
    drive(2'b01, mk(K_MUL, 12, 1, 2, 32'h200), '0);
    at_neg(); check("mul_r12_issue", 32'(issue_o), 32'h1);
    tick();
    wb_valid_i = 2'b00;
    drive(2'b01, mk(K_ALU, 13, 12, 1, 32'h204), '0);
    at_neg(); check("set_wins", 32'(issue_o), 32'h0);
    tick();
    drive(2'b11, mk(K_ALU, 4, 1, 2, 32'h208), mk(K_ALU, 5, 1, 3, 32'h20C));
    at_neg(); check("pair_with_sb_busy", 32'(issue_o), 32'h3);
    tick();
    flush_i = 1'b1;
    at_neg(); check("flush_issue", 32'(issue_o), 32'h0);
    check("ex_before_flush", 32'(ex_valid_o), 32'h3);
    tick();
    flush_i = 1'b0;
    drive(2'b01, mk(K_ALU, 13, 12, 1, 32'h210), '0);
    at_neg(); check("ex_after_flush", 32'(ex_valid_o), 32'h0);
    check("sb_cleared_by_flush", 32'(issue_o), 32'h1);
    tick();
    idle();

    // EX back-pressure holds the EX register
    drive(2'b11, mk(K_ALU, 4, 1, 2, 32'h300), mk(K_ALU, 5, 1, 3, 32'h304));
    at_neg(); check("hold_first_issue", 32'(issue_o), 32'h3);
    tick();
    drive(2'b11, mk(K_ALU, 6, 1, 2, 32'h400), mk(K_ALU, 7, 1, 3, 32'h404));
    ex_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      check($sformatf("hold%0d_issue", c), 32'(issue_o), 32'h0);
      check($sformatf("hold%0d_ex_valid", c), 32'(ex_valid_o), 32'h3);
      check($sformatf("hold%0d_ex_pc", c), ex_inst_o[0].pc, 32'h300);
      tick();
    end
    ex_ready_i = 1'b1;
    at_neg(); check("release_issue", 32'(issue_o), 32'h3);
    tick();
    idle();
    at_neg(); check("release_ex_pc0", ex_inst_o[0].pc, 32'h400);
    check("release_ex_pc1", ex_inst_o[1].pc, 32'h404);
    tick();

    // Reset in the middle of a stall drops the scoreboard
    drive(2'b01, mk(K_LD, 6, 1, 0, 32'h500), '0);
    at_neg(); check("rst_ld_issue", 32'(issue_o), 32'h1);
    tick();
    drive(2'b01, mk(K_ALU, 7, 6, 1, 32'h504), '0);
    at_neg(); check("rst_stall", 32'(issue_o), 32'h0);
    tick();
    rst_n = 1'b0;
    at_neg(); check("issue_in_reset", 32'(issue_o), 32'h0);
    tick();
    rst_n = 1'b1;
    at_neg(); check("sb_cleared_by_reset", 32'(issue_o), 32'h1);
    tick();
    idle();

    // Random invariants against a shadow scoreboard
    flush_i = 1'b1;
    tick();
    tb_sb = '0;
    for (int n = 0; n < 300; n++) begin
      logic [1:0] vpat;
      logic viol;
      logic [31:0] nsb;
      case ($urandom_range(0, 2))
        0: vpat = 2'b00;
        1: vpat = 2'b01;
        default: vpat = 2'b11;
      endcase
      drive(vpat,
            mk(int'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 32'(n * 8)),
            mk(int'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 32'(n * 8 + 4)));
      ex_ready_i    = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 15) == 0);
      wb_valid_i[0] = ($urandom_range(0, 2) == 0);
      wb_valid_i[1] = ($urandom_range(0, 2) == 0);
      wb_reg_i[0]   = 5'($urandom_range(0, 7));
      wb_reg_i[1]   = 5'($urandom_range(0, 7));
      at_neg();
      check("rand_prefix", 32'(issue_o == 2'b10), 32'h0);
      viol = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (issue_o[s]) begin
          for (int q = 0; q < 3; q++) begin
            logic [4:0] r;
            r = (q == 2) ? inst_i[s].reg_info.w_reg : inst_i[s].reg_info.r_reg[q];
            if (r != 5'd0 && tb_sb[r]) viol = 1'b1;
          end
        end
      end
      check("rand_no_pending", 32'(viol), 32'h0);
      nsb = tb_sb;
      for (int p = 0; p < 2; p++)
        if (wb_valid_i[p] && wb_reg_i[p] != 5'd0) nsb[wb_reg_i[p]] = 1'b0;
      for (int s = 0; s < 2; s++)
        if (issue_o[s] && (inst_i[s].decode_info.is_load || inst_i[s].decode_info.is_mul ||
                           inst_i[s].decode_info.is_div) && inst_i[s].reg_info.w_reg != 5'd0)
          nsb[inst_i[s].reg_info.w_reg] = 1'b1;
      if (flush_i) nsb = '0;
      tb_sb = nsb;
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
